// File: rtl/osd_io_seq_if.sv
// Control/payload/OSD-bus signal bundle for osd_io_seq.
// Payload handshake: a word transfers on a rising clk_sys edge where wr_valid && wr_ready.
interface osd_io_seq_if;
  logic        start;
  logic [7:0]  cmd;
  logic [12:0] len;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        abort;
  logic        busy;
  logic        done;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;

  modport master (
    output start, cmd, len, wr_valid, wr_data, abort,
    input  wr_ready, busy, done, io_osd, io_strobe, io_din
  );

  modport slave (
    input  start, cmd, len, wr_valid, wr_data, abort,
    output wr_ready, busy, done, io_osd, io_strobe, io_din
  );
endinterface

// File: rtl/osd_io_seq.sv
// OSD command-bus master: frames a command byte plus queued payload words with io_osd,
// one io_strobe per word, fixed setup/high/low phases and an inter-frame gap.
module osd_io_seq #(
  parameter int FIFO_AW = 4,
  parameter int SETUP   = 1,
  parameter int STB_HI  = 2,
  parameter int STB_LO  = 2,
  parameter int GAP     = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  osd_io_seq_if.slave        bus,
  output logic [2:0]         dbg_state,
  output logic [FIFO_AW:0]   dbg_fifo_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_LOAD  = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [3:0]       T_SETUP  = 4'(SETUP - 1);
  localparam logic [3:0]       T_HI     = 4'(STB_HI - 1);
  localparam logic [3:0]       T_LO     = 4'(STB_LO - 1);
  localparam logic [3:0]       T_GAP    = 4'(GAP - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [12:0]      LEN_MAX  = 13'd4096;

  // ---------------- payload FIFO (first-word-fall-through) ----------------
  logic [15:0]        mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               wr_ready_q;
  logic               push, pop, flush, empty;
  logic [15:0]        head;

  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr];
  assign push  = bus.wr_valid && wr_ready_q && !flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count_q    <= count_d;
      wr_ready_q <= (count_d != FULL_CNT);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // ---------------- frame sequencer ----------------
  state_t      state_q, state_d;
  logic [3:0]  tmr_q, tmr_d;
  logic [12:0] rem_q, rem_d;
  logic [15:0] din_q, din_d;
  logic        osd_q, osd_d;
  logic        stb_q, stb_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [12:0] len_sat;

  assign len_sat = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      rem_q   <= '0;
      din_q   <= '0;
      osd_q   <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
      osd_q   <= osd_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    din_d   = din_q;
    osd_d   = osd_q;
    stb_d   = stb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;

    if (bus.abort && (state_q inside {S_SETUP, S_HI, S_LO, S_LOAD})) begin
      // A strobe already raised stays delivered; we only stop driving the bus.
      flush   = 1'b1;
      osd_d   = 1'b0;
      stb_d   = 1'b0;
      din_d   = '0;
      tmr_d   = T_GAP;
      state_d = S_END;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.abort) begin
            flush = 1'b1;
          end else if (bus.start) begin
            rem_d   = len_sat;
            din_d   = {8'h00, bus.cmd};
            osd_d   = 1'b1;
            busy_d  = 1'b1;
            tmr_d   = T_SETUP;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_q == '0) begin
            stb_d   = 1'b1;
            tmr_d   = T_HI;
            state_d = S_HI;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_HI: begin
          if (tmr_q == '0) begin
            stb_d   = 1'b0;
            tmr_d   = T_LO;
            state_d = S_LO;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_LO: begin
          if (tmr_q == '0) begin
            // With the next word already queued, the pop folds into the last low
            // cycle so back-to-back words keep a SETUP+STB_HI+STB_LO period.
            if (rem_q != '0 && !empty) begin
              pop     = 1'b1;
              din_d   = head;
              rem_d   = rem_q - 1'b1;
              tmr_d   = T_SETUP;
              state_d = S_SETUP;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_LOAD: begin
          if (rem_q == '0) begin
            osd_d   = 1'b0;
            din_d   = '0;
            tmr_d   = T_GAP;
            state_d = S_END;
          end else if (!empty) begin
            pop     = 1'b1;
            din_d   = head;
            rem_d   = rem_q - 1'b1;
            tmr_d   = T_SETUP;
            state_d = S_SETUP;
          end
        end
        S_END: begin
          if (tmr_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.io_osd    = osd_q;
  assign bus.io_strobe = stb_q;
  assign bus.io_din    = din_q;

  assign dbg_state      = state_q;
  assign dbg_fifo_count = count_q;

endmodule

// File: tb/tb_osd_io_seq.sv
// Directed bench for osd_io_seq: a monitor checks every strobed word against a queue of
// expected words filled when each transaction is issued.
module tb_osd_io_seq;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_END  = 3'd5;

  logic        clk_sys;
  logic        reset;
  logic [2:0]  dbg_state;
  logic [4:0]  dbg_fifo_count;

  osd_io_seq_if bus ();

  osd_io_seq dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // ---------------- clock / reset ----------------
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          strobe_cnt = 0;
  int          done_cnt   = 0;
  logic        stb_prev = 1'b0;
  logic [15:0] rise_din = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each strobe rising edge with the head of the expected queue.
  always @(negedge clk_sys) begin
    if (reset) begin
      stb_prev = 1'b0;
    end else begin
      if (bus.io_strobe && !stb_prev) begin
        strobe_cnt++;
        rise_din = bus.io_din;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got io_din 0x%0h expected no strobe at %0t",
                   bus.io_din, $time);
        end else begin
          check("strobe_word", {16'h0, bus.io_din}, {16'h0, exp_q.pop_front()});
        end
      end else if (bus.io_strobe && stb_prev) begin
        check("din_stable_hi", {16'h0, bus.io_din}, {16'h0, rise_din});
      end
      if (bus.done) done_cnt++;
      stb_prev = bus.io_strobe;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push_word(input logic [15:0] data);
    int waited;
    waited = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = data;
    while (!bus.wr_ready && waited < 100) begin
      tick(1);
      waited++;
    end
    if (!bus.wr_ready) check("push_timeout", 32'd0, 32'd1);
    tick(1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic start_txn(input logic [7:0] c, input logic [12:0] l);
    bus.start = 1'b1;
    bus.cmd   = c;
    bus.len   = l;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    if (!bus.done) check("done_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  // Counts io_osd-high cycles and the cycle index of done, counting from the start cycle.
  task automatic measure_frame(output int osd_cycles, output int done_idx, output int rise_idx);
    osd_cycles = 0;
    done_idx   = -1;
    rise_idx   = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk_sys);
      if (bus.io_osd) osd_cycles++;
      if (bus.io_strobe && rise_idx < 0) rise_idx = k;
      if (bus.done) begin
        done_idx = k;
        break;
      end
    end
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int osd_c, done_i, rise_i, s0, d0;

    bus.start = 1'b0; bus.cmd = '0; bus.len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.abort = 1'b0;
    reset = 1'b1;
    #22;
    check("rst_io_osd",    {31'h0, bus.io_osd},    32'd0);
    check("rst_io_strobe", {31'h0, bus.io_strobe}, 32'd0);
    check("rst_io_din",    {16'h0, bus.io_din},    32'd0);
    check("rst_busy",      {31'h0, bus.busy},      32'd0);
    check("rst_wr_ready",  {31'h0, bus.wr_ready},  32'd0);
    reset = 1'b0;
    tick(1);
    check("wr_ready_after_rst", {31'h0, bus.wr_ready}, 32'd1);
    check("state_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});

    // 1: command-only frame
    exp_q.push_back(16'h0041);
    start_txn(8'h41, 13'd0);
    check("t1_busy", {31'h0, bus.busy}, 32'd1);
    measure_frame(osd_c, done_i, rise_i);
    check("t1_osd_cycles", osd_c, 32'd6);
    check("t1_rise_cycle", rise_i, 32'd2);
    check("t1_done_cycle", done_i, 32'd11);
    check("t1_busy_end", {31'h0, bus.busy}, 32'd0);
    check("t1_strobes", strobe_cnt, 32'd1);

    // 2: preloaded payload of 8 words
    for (int i = 0; i < 8; i++) push_word(16'h00A0 + 16'(i));
    check("t2_preload_count", {27'h0, dbg_fifo_count}, 32'd8);
    s0 = strobe_cnt;
    exp_q.push_back(16'h0020);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h00A0 + 16'(i));
    start_txn(8'h20, 13'd8);
    measure_frame(osd_c, done_i, rise_i);
    check("t2_osd_cycles", osd_c, 32'd46);
    check("t2_done_cycle", done_i, 32'd51);
    check("t2_strobes", strobe_cnt - s0, 32'd9);
    check("t2_fifo_empty", {27'h0, dbg_fifo_count}, 32'd0);
    check("t2_exp_drained", exp_q.size(), 32'd0);

    // 3: slow producer, LOAD stalls
    s0 = strobe_cnt;
    exp_q.push_back(16'h0033);
    for (int i = 0; i < 20; i++) exp_q.push_back(16'hB000 + 16'(i));
    start_txn(8'h33, 13'd20);
    for (int i = 0; i < 20; i++) begin
      push_word(16'hB000 + 16'(i));
      tick(9);
    end
    wait_done(300);
    check("t3_strobes", strobe_cnt - s0, 32'd21);
    check("t3_exp_drained", exp_q.size(), 32'd0);

    // 4: abort during the high phase of the third strobe
    for (int i = 0; i < 4; i++) push_word(16'hC000 + 16'(i));
    s0 = strobe_cnt; d0 = done_cnt;
    exp_q.push_back(16'h0044);
    exp_q.push_back(16'hC000);
    exp_q.push_back(16'hC001);
    start_txn(8'h44, 13'd4);
    for (int k = 0; k < 100 && strobe_cnt - s0 < 3; k++) begin
      @(negedge clk_sys);
      #1;
    end
    check("t4_third_strobe_seen", strobe_cnt - s0, 32'd3);
    check("t4_in_hi", {31'h0, bus.io_strobe}, 32'd1);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("t4_abort_strobe", {31'h0, bus.io_strobe}, 32'd0);
    check("t4_abort_osd",    {31'h0, bus.io_osd},    32'd0);
    check("t4_abort_fifo",   {27'h0, dbg_fifo_count}, 32'd0);
    check("t4_abort_state",  {29'h0, dbg_state}, {29'h0, ST_END});
    wait_done(20);
    check("t4_done", done_cnt - d0, 32'd1);
    check("t4_busy", {31'h0, bus.busy}, 32'd0);
    check("t4_strobes", strobe_cnt - s0, 32'd3);

    // 5: reset during the low phase of word 2
    for (int i = 0; i < 2; i++) push_word(16'hD000 + 16'(i));
    s0 = strobe_cnt;
    exp_q.push_back(16'h0055);
    exp_q.push_back(16'hD000);
    start_txn(8'h55, 13'd2);
    for (int k = 0; k < 100 && strobe_cnt - s0 < 2; k++) @(negedge clk_sys);
    for (int k = 0; k < 10 && bus.io_strobe; k++) @(negedge clk_sys);
    #1;
    check("t5_in_lo_osd", {31'h0, bus.io_osd}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_osd",    {31'h0, bus.io_osd},    32'd0);
    check("t5_rst_strobe", {31'h0, bus.io_strobe}, 32'd0);
    check("t5_rst_din",    {16'h0, bus.io_din},    32'd0);
    check("t5_rst_busy",   {31'h0, bus.busy},      32'd0);
    check("t5_rst_fifo",   {27'h0, dbg_fifo_count}, 32'd0);
    #1;
    reset = 1'b0;
    exp_q.delete();
    tick(1);
    check("t5_wr_ready", {31'h0, bus.wr_ready}, 32'd1);
    push_word(16'hE001);
    s0 = strobe_cnt; d0 = done_cnt;
    exp_q.push_back(16'h0056);
    exp_q.push_back(16'hE001);
    start_txn(8'h56, 13'd1);
    wait_done(50);
    check("t5_strobes", strobe_cnt - s0, 32'd2);
    check("t5_done", done_cnt - d0, 32'd1);
    check("t5_exp_drained", exp_q.size(), 32'd0);

    // 6: start while busy, then start+abort together in IDLE
    s0 = strobe_cnt; d0 = done_cnt;
    exp_q.push_back(16'h0060);
    start_txn(8'h60, 13'd0);
    tick(2);
    bus.start = 1'b1; bus.cmd = 8'h66; bus.len = 13'd3;
    tick(1);
    bus.start = 1'b0;
    wait_done(30);
    tick(10);
    check("t6_busy_start_strobes", strobe_cnt - s0, 32'd1);
    check("t6_busy_start_done", done_cnt - d0, 32'd1);
    push_word(16'hF000);
    push_word(16'hF001);
    s0 = strobe_cnt; d0 = done_cnt;
    bus.start = 1'b1; bus.abort = 1'b1; bus.cmd = 8'h77; bus.len = 13'd0;
    tick(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t6_idle_busy", {31'h0, bus.busy}, 32'd0);
    check("t6_idle_flush", {27'h0, dbg_fifo_count}, 32'd0);
    tick(20);
    check("t6_no_done", done_cnt - d0, 32'd0);
    check("t6_no_strobe", strobe_cnt - s0, 32'd0);
    check("t6_state_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
